// File: rtl/mips_pkg.sv
// Shared MIPS control constants: main-state codes, instruction class codes,
// and the opcode/funct values the control unit and register bank agree on.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_INIT      = 3'b000,
        ST_FETCH     = 3'b001,
        ST_DECODE    = 3'b010,
        ST_EXECUTE   = 3'b011,
        ST_MEM       = 3'b100,
        ST_TRAP      = 3'b101,
        ST_WRITEBACK = 3'b110
    } uc_state_e;

    localparam logic [7:0] CLS_NONE = 8'h00;
    localparam logic [7:0] CLS_R    = 8'h01;
    localparam logic [7:0] CLS_SW   = 8'h02;
    localparam logic [7:0] CLS_IMM  = 8'h03;
    localparam logic [7:0] CLS_BEQ  = 8'h04;
    localparam logic [7:0] CLS_J    = 8'h05;
    localparam logic [7:0] CLS_LW   = 8'h06;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

endpackage

// File: rtl/decodificador_instr.sv
// Combinational instruction decoder: maps an instruction word to its class
// code, the register-bank write address for that class, and a valid flag.
module decodificador_instr
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic [7:0]  cls,
    output logic [4:0]  rd,
    output logic        valid
);

    always_comb begin
        cls   = CLS_NONE;
        valid = 1'b1;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: cls = CLS_R;
                    default:                               valid = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: cls = CLS_IMM;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            OP_J:    cls = CLS_J;
            default: valid = 1'b0;
        endcase
    end

    // R-type writes rd; immediate ops and loads write rt; others write nothing.
    always_comb begin
        rd = 5'd0;
        if (cls == CLS_R)
            rd = instr[15:11];
        else if (cls == CLS_IMM || cls == CLS_LW)
            rd = instr[20:16];
    end

endmodule

// File: rtl/unidade_de_controle.sv
// Multi-cycle MIPS control unit: INIT/FETCH/DECODE/EXECUTE/MEM/WRITEBACK FSM.
// Optional macro UC_TRAP_INVALID_EN sends invalid instructions to a sticky TRAP.
module unidade_de_controle
    import mips_pkg::*;
#(
    parameter int INIT_CYCLES = 2
) (
    input  logic        uc_in_clk,
    input  logic        uc_in_rst_n,
    input  logic [31:0] uc_in_instr,
    input  logic        uc_in_mem_ready,
    output logic [2:0]  uc_out_FSM,
    output logic [7:0]  uc_out_FSM2,
    output logic [4:0]  uc_out_rs,
    output logic [4:0]  uc_out_rt,
    output logic [4:0]  uc_out_rd,
    output logic [31:0] uc_out_imm,
    output logic        uc_out_mem_req,
    output logic        uc_out_mem_we,
    output logic        uc_out_pc_we,
    output logic [31:0] uc_out_instr_count,
    output logic        uc_out_trap
);

    localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    uc_state_e       state_q, state_d;
    logic [CW-1:0]   init_cnt_q;
    logic [31:0]     instr_q;
    logic [31:0]     count_q;
    logic [7:0]      cls;
    logic [4:0]      rd_sel;
    logic            valid;
    logic            init_done;
    logic            retire;

    decodificador_instr u_dec (
        .instr (instr_q),
        .cls   (cls),
        .rd    (rd_sel),
        .valid (valid)
    );

    assign init_done = (init_cnt_q == CW'(INIT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   if (init_done) state_d = ST_FETCH;
            ST_FETCH:  if (uc_in_mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                state_d = ST_EXECUTE;
`ifdef UC_TRAP_INVALID_EN
                if (!valid) state_d = ST_TRAP;
`endif
            end
            ST_EXECUTE: begin
                case (cls)
                    // A zero destination skips writeback so $zero is never written.
                    CLS_R, CLS_IMM: state_d = (rd_sel == 5'd0) ? ST_FETCH : ST_WRITEBACK;
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    default:        state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (uc_in_mem_ready)
                    state_d = (cls == CLS_LW && rd_sel != 5'd0) ? ST_WRITEBACK : ST_FETCH;
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_INIT;
        endcase
    end

    // Only completed instructions count; the INIT->FETCH entry does not.
    assign retire = (state_d == ST_FETCH) && (state_q != ST_INIT) && (state_q != ST_FETCH);

    always_ff @(posedge uc_in_clk or negedge uc_in_rst_n) begin
        if (!uc_in_rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            instr_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT && !init_done)
                init_cnt_q <= init_cnt_q + CW'(1);
            if (state_q == ST_FETCH && uc_in_mem_ready)
                instr_q <= uc_in_instr;
            if (retire)
                count_q <= count_q + 32'd1;
        end
    end

    assign uc_out_FSM         = state_q;
    assign uc_out_FSM2        = (state_q == ST_INIT || state_q == ST_FETCH || !valid) ? CLS_NONE : cls;
    assign uc_out_rs          = instr_q[25:21];
    assign uc_out_rt          = instr_q[20:16];
    assign uc_out_rd          = rd_sel;
    assign uc_out_imm         = {{16{instr_q[15]}}, instr_q[15:0]};
    assign uc_out_mem_req     = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign uc_out_mem_we      = (state_q == ST_MEM) && (cls == CLS_SW);
    assign uc_out_pc_we       = (state_q == ST_EXECUTE) && (cls == CLS_BEQ || cls == CLS_J);
    assign uc_out_instr_count = count_q;

`ifdef UC_TRAP_INVALID_EN
    assign uc_out_trap = (state_q == ST_TRAP);
`else
    assign uc_out_trap = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_de_controle.sv
// Bench for unidade_de_controle: random MIPS instruction stream with a memory
// responder, per-cycle and per-instruction expectations held in queues.
module tb_unidade_de_controle;

`ifdef UC_TRAP_INVALID_EN
    localparam bit TRAP_BUILD = 1'b1;
`else
    localparam bit TRAP_BUILD = 1'b0;
`endif
    localparam int TRAP_CYC = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic [2:0]  fsm;
    logic [7:0]  fsm2;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic        mem_req, mem_we, pc_we, trap;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    unidade_de_controle #(.INIT_CYCLES(2)) dut (
        .uc_in_clk          (clk),
        .uc_in_rst_n        (rst_n),
        .uc_in_instr        (instr),
        .uc_in_mem_ready    (mem_ready),
        .uc_out_FSM         (fsm),
        .uc_out_FSM2        (fsm2),
        .uc_out_rs          (rs),
        .uc_out_rt          (rt),
        .uc_out_rd          (rd),
        .uc_out_imm         (imm),
        .uc_out_mem_req     (mem_req),
        .uc_out_mem_we      (mem_we),
        .uc_out_pc_we       (pc_we),
        .uc_out_instr_count (instr_count),
        .uc_out_trap        (trap)
    );

    int n_checks = 0;
    int n_err    = 0;
    int model_count = 0;
    logic mon_en = 1'b0;

    // per cycle: {state[2:0], mem_req, mem_we, pc_we, trap}
    logic [6:0]  exp_q[$];
    // per instruction: {cls8, cls_chk, rs5, rt5, rd5, rd_chk, imm32, count32}
    logic [88:0] rec_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] cyc(input logic [2:0] st, input logic req, input logic we,
                                       input logic pc, input logic tr);
        return {st, req, we, pc, tr};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [2:0]  prev_fsm = 3'b000;
    logic [88:0] cur = '0;
    logic [6:0]  e;

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("fsm",     32'(fsm),     32'(e[6:4]));
                check("mem_req", 32'(mem_req), 32'(e[3]));
                check("mem_we",  32'(mem_we),  32'(e[2]));
                check("pc_we",   32'(pc_we),   32'(e[1]));
                check("trap",    32'(trap),    32'(e[0]));
            end
            if (fsm == 3'b010 && prev_fsm != 3'b010) begin
                if (rec_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL decode_unexpected: got DECODE with no instruction issued at %0t", $time);
                end else begin
                    cur = rec_q.pop_front();
                    if (cur[80]) check("fsm2", 32'(fsm2), 32'(cur[88:81]));
                    check("rs",  32'(rs), 32'(cur[79:75]));
                    check("rt",  32'(rt), 32'(cur[74:70]));
                    if (cur[64]) check("rd", 32'(rd), 32'(cur[69:65]));
                    check("imm", imm, cur[63:32]);
                end
            end
            if (fsm == 3'b001 && (prev_fsm inside {3'b010, 3'b011, 3'b100, 3'b110}))
                check("instr_count", instr_count, cur[31:0]);
            prev_fsm = fsm;
        end else begin
            prev_fsm = 3'b000;
        end
    end

    // ---------------- driver ----------------
    task automatic run_instr(input logic [31:0] ins, input logic [7:0] cls, input logic valid,
                             input int flat, input int mlat);
        logic [4:0] erd;
        logic rd_chk, is_mem, is_sw, wb, pc, trap_path;
        rd_chk    = (cls == 8'h01 || cls == 8'h03 || cls == 8'h06);
        erd       = (cls == 8'h01) ? ins[15:11] : (rd_chk ? ins[20:16] : 5'd0);
        is_mem    = (cls == 8'h06 || cls == 8'h02);
        is_sw     = (cls == 8'h02);
        wb        = rd_chk && (erd != 5'd0);
        pc        = (cls == 8'h04 || cls == 8'h05);
        trap_path = TRAP_BUILD && !valid;
        if (!trap_path) model_count++;
        rec_q.push_back({cls, !trap_path, ins[25:21], ins[20:16], erd, rd_chk,
                         {{16{ins[15]}}, ins[15:0]}, 32'(model_count)});
        for (int i = 0; i <= flat; i++) exp_q.push_back(cyc(3'b001, 1, 0, 0, 0));
        exp_q.push_back(cyc(3'b010, 0, 0, 0, 0));
        if (trap_path) begin
            for (int i = 0; i < TRAP_CYC; i++) exp_q.push_back(cyc(3'b101, 0, 0, 0, 1));
        end else begin
            exp_q.push_back(cyc(3'b011, 0, 0, pc, 0));
            if (is_mem) for (int i = 0; i < mlat; i++) exp_q.push_back(cyc(3'b100, 1, is_sw, 0, 0));
            if (wb) exp_q.push_back(cyc(3'b110, 0, 0, 0, 0));
        end

        for (int i = 0; i < flat; i++) begin
            @(posedge clk); #1; mem_ready = 1'b0; instr = $urandom;
        end
        @(posedge clk); #1; mem_ready = 1'b1; instr = ins;
        @(posedge clk); #1; mem_ready = 1'($urandom); instr = $urandom;
        if (trap_path) begin
            for (int i = 0; i < TRAP_CYC; i++) begin
                @(posedge clk); #1; mem_ready = 1'($urandom);
            end
        end else begin
            @(posedge clk); #1; mem_ready = 1'($urandom);
            if (is_mem) for (int i = 0; i < mlat; i++) begin
                @(posedge clk); #1; mem_ready = (i == mlat - 1);
            end
            if (wb) begin
                @(posedge clk); #1; mem_ready = 1'($urandom);
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_fsm",   32'(fsm),     32'd0);
        check("rst_fsm2",  32'(fsm2),    32'd0);
        check("rst_rs",    32'(rs),      32'd0);
        check("rst_rt",    32'(rt),      32'd0);
        check("rst_rd",    32'(rd),      32'd0);
        check("rst_imm",   imm,          32'd0);
        check("rst_req",   32'(mem_req), 32'd0);
        check("rst_we",    32'(mem_we),  32'd0);
        check("rst_pc_we", 32'(pc_we),   32'd0);
        check("rst_count", instr_count,  32'd0);
        check("rst_trap",  32'(trap),    32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        mem_ready = 1'($urandom);
        exp_q.push_back(cyc(3'b000, 0, 0, 0, 0));
        @(posedge clk); #1;
        mem_ready = 1'($urandom);
        exp_q.push_back(cyc(3'b000, 0, 0, 0, 0));
    endtask

    task automatic assert_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        rec_q.delete();
        model_count = 0;
        @(posedge clk); #1;
        check("rst_hold_fsm",   32'(fsm),    32'd0);
        check("rst_hold_count", instr_count, 32'd0);
    endtask

    function automatic bit op_known(input logic [5:0] op);
        return op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43};
    endfunction

    task automatic rand_instr(output logic [31:0] ins, output logic [7:0] cls, output logic valid);
        int k;
        logic [4:0] frs, frt, frd;
        logic [15:0] i16;
        logic [5:0] op;
        logic [5:0] fn_tab [5];
        logic [5:0] op_tab [4];
        fn_tab = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        op_tab = '{6'd8, 6'd10, 6'd12, 6'd13};
        k   = $urandom_range(0, TRAP_BUILD ? 12 : 13);
        frs = 5'($urandom);
        frt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        frd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        i16 = 16'($urandom);
        valid = 1'b1;
        if (k <= 4) begin
            ins = {6'd0, frs, frt, frd, 5'($urandom), fn_tab[k]}; cls = 8'h01;
        end else if (k <= 8) begin
            ins = {op_tab[k-5], frs, frt, i16}; cls = 8'h03;
        end else if (k == 9) begin
            ins = {6'd35, frs, frt, i16}; cls = 8'h06;
        end else if (k == 10) begin
            ins = {6'd43, frs, frt, i16}; cls = 8'h02;
        end else if (k == 11) begin
            ins = {6'd4, frs, frt, i16}; cls = 8'h04;
        end else if (k == 12) begin
            ins = {6'd2, 26'($urandom)}; cls = 8'h05;
        end else begin
            cls = 8'h00; valid = 1'b0;
            if ($urandom_range(0, 1) == 0) begin
                ins = {6'd0, frs, frt, frd, 5'd0, 6'd8};
            end else begin
                op = 6'($urandom);
                while (op_known(op)) op = 6'($urandom);
                ins = {op, frs, frt, i16};
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ins;
        logic [7:0]  cls;
        logic        valid;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        instr = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        release_reset();

        run_instr(32'h0109_5020, 8'h01, 1'b1, 0, 1);   // add $t2,$t0,$t1
        run_instr(32'h8FB0_0004, 8'h06, 1'b1, 1, 3);   // lw $s0,4($sp)
        run_instr(32'h2000_0005, 8'h03, 1'b1, 0, 1);   // addi $zero,$zero,5
        run_instr(32'h8C00_FFF0, 8'h06, 1'b1, 2, 2);   // lw $zero,-16($zero)
        run_instr(32'h1109_FFFE, 8'h04, 1'b1, 0, 1);   // beq
        run_instr(32'h0800_0040, 8'h05, 1'b1, 1, 1);   // j
        run_instr(32'hAFA8_8008, 8'h02, 1'b1, 0, 4);   // sw, negative offset
        if (!TRAP_BUILD) run_instr(32'hFC00_0000, 8'h00, 1'b0, 0, 1);

        for (int n = 0; n < 60; n++) begin
            rand_instr(ins, cls, valid);
            run_instr(ins, cls, valid, $urandom_range(0, 3), $urandom_range(1, 4));
        end

        // sw abandoned by reset while in MEM
        rec_q.push_back({8'h02, 1'b1, 5'd29, 5'd8, 5'd0, 1'b0, 32'h0000_0008, 32'(model_count + 1)});
        exp_q.push_back(cyc(3'b001, 1, 0, 0, 0));
        exp_q.push_back(cyc(3'b010, 0, 0, 0, 0));
        exp_q.push_back(cyc(3'b011, 0, 0, 0, 0));
        @(posedge clk); #1; mem_ready = 1'b1; instr = 32'hAFA8_0008;
        @(posedge clk); #1; mem_ready = 1'b0;
        @(posedge clk); #1; mem_ready = 1'b0;
        @(posedge clk); #1; mem_ready = 1'b0; mon_en = 1'b0;
        check("mid_sw_fsm", 32'(fsm),    32'd4);
        check("mid_sw_req", 32'(mem_req), 32'd1);
        check("mid_sw_we",  32'(mem_we),  32'd1);
        #1;
        assert_reset();
        release_reset();
        run_instr(32'h0109_5020, 8'h01, 1'b1, 1, 1);

        if (TRAP_BUILD) begin
            run_instr(32'hFC00_0000, 8'h00, 1'b0, 0, 1);
            #1;
            assert_reset();
            release_reset();
            run_instr(32'h0109_5020, 8'h01, 1'b1, 0, 1);
        end

        @(posedge clk); #1; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("rec_q_drained", 32'(rec_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_err++;
        $display("FAIL timeout: simulation did not complete by %0t", $time);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/unidade_de_controle.md
UNIDADE_DE_CONTROLE -- requirements
Module: unidade_de_controle

Interface
REQ-001 Parameter INIT_CYCLES, default 2, number of cycles held in state INIT after reset release (minimum 1).
REQ-002 uc_in_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 uc_in_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 uc_in_instr  input  32  instruction word from instruction memory, valid when uc_in_mem_ready=1 in FETCH.
REQ-005 uc_in_mem_ready  input  1  memory completion strobe for the current request.
REQ-006 uc_out_FSM  output  3  main state code, drives register-bank FSM input.
REQ-007 uc_out_FSM2  output  8  instruction class code, drives register-bank FSM2 input.
REQ-008 uc_out_rs, uc_out_rt, uc_out_rd  output  5 each  source addresses and write-destination address.
REQ-009 uc_out_imm  output  32  sign-extended instr[15:0].
REQ-010 uc_out_mem_req / uc_out_mem_we  output  1 each  memory request; write qualifier.
REQ-011 uc_out_pc_we  output  1  one-cycle PC update pulse for BEQ/J.
REQ-012 uc_out_instr_count  output  32  retired-instruction counter.
REQ-013 uc_out_trap  output  1  sticky invalid-instruction flag (UC_TRAP_INVALID_EN only; else tied 0).

Function
REQ-014 State codes SHALL be INIT=000, FETCH=001, DECODE=010, EXECUTE=011, MEM=100, TRAP=101, WRITEBACK=110.
REQ-015 INIT SHALL last exactly INIT_CYCLES cycles, then go to FETCH.
REQ-016 FETCH SHALL hold mem_req=1, mem_we=0; on mem_ready=1 latch instr and go to DECODE; otherwise stay indefinitely.
REQ-017 DECODE and EXECUTE SHALL each last exactly one cycle.
REQ-018 Class codes: R-type (opcode 000000, funct add/sub/and/or/slt) 0x01; addi/slti/andi/ori 0x03; lw 0x06; sw 0x02; beq 0x04; j 0x05; anything else invalid.
REQ-019 uc_out_FSM2 SHALL be 0x00 in INIT and FETCH and hold the decoded code from DECODE until re-entry to FETCH.
REQ-020 uc_out_rd SHALL be instr[15:11] for class 0x01 and instr[20:16] for 0x03/0x06; rs=instr[25:21], rt=instr[20:16], held from DECODE on.
REQ-021 From EXECUTE: 0x01/0x03 -> WRITEBACK; 0x06/0x02 -> MEM; 0x04/0x05 -> FETCH with pc_we=1 for that EXECUTE cycle.
REQ-022 MEM SHALL hold mem_req=1, mem_we=1 only for 0x02; on mem_ready: 0x06 -> WRITEBACK, 0x02 -> FETCH.
REQ-023 If destination is 0 for 0x01/0x03/0x06, WRITEBACK SHALL be skipped (go to FETCH), so $zero is never written.
REQ-024 WRITEBACK SHALL last one cycle, then FETCH.
REQ-025 instr_count SHALL increment by 1 on each transition into FETCH from DECODE-path states (not from INIT), wrapping 0xFFFFFFFF->0.
REQ-026 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-027 On rst_n=0 all outputs SHALL go immediately to: FSM=000, FSM2=0x00, rs/rt/rd=0, imm=0, mem_req=0, mem_we=0, pc_we=0, instr_count=0, trap=0.
REQ-028 Reset mid-instruction SHALL abandon it without counting; INIT count restarts.

Configuration
REQ-029 Macro UC_TRAP_INVALID_EN defined: invalid instruction goes DECODE -> TRAP, sets trap=1, remains until reset, no memory or PC activity.
REQ-030 Macro undefined: invalid instruction treated as NOP (FSM2=0x00, DECODE -> EXECUTE -> FETCH, counted), trap constant 0.

Structure
REQ-031 State codes, class codes and opcode/funct constants SHALL live in shared package mips_pkg, also used by the register bank.
REQ-032 Instruction decode SHALL be one combinational sub-module, decodificador_instr (instr -> class, rd select, valid).

Verification
REQ-033 Reset release, INIT_CYCLES=2 -> FSM 000 for 2 cycles then 001, mem_req=1.
REQ-034 add $t2,$t0,$t1 (0x01095020), ready immediate -> 001,010,011,110; FSM2=0x01, rd=10, count=1.
REQ-035 lw $s0,4($sp) (0x8FB00004), MEM ready after 3 cycles -> MEM held 3 cycles, then 110 with FSM2=0x06, rd=16, imm=0x4.
REQ-036 addi $zero,$zero,5 (0x20000005) -> no 110 state; back to FETCH, count incremented.
REQ-037 Opcode 0x3F: with macro -> FSM=101, trap=1 held; without -> FSM2=0x00, count incremented.
REQ-038 rst_n low during MEM of sw -> mem_req drops same cycle, count unchanged, INIT restarts.
